// File: rtl/fifo_uart_tx_if.sv
// Read-side bundle between the FIFO and the UART drain stage.
// The drain stage is the master: it issues rd and consumes empty/dout.
interface fifo_uart_tx_if;
    logic       fifo_rd;
    logic       fifo_empty;
    logic [7:0] fifo_dout;

    modport master (
        output fifo_rd,
        input  fifo_empty,
        input  fifo_dout
    );

    modport slave (
        input  fifo_rd,
        output fifo_empty,
        output fifo_dout
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the FIFO and serialises them as 8N1 on txd.
// One pop per frame; the FIFO is only read from IDLE.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    fifo_uart_tx_if.master fifo,
    output logic           txd,
    output logic           busy
);
    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;
    logic        rd_q, rd_d;
    logic        busy_q, busy_d;
    logic        bit_end;

    assign bit_end      = (cnt_q == LAST);
    assign txd          = txd_q;
    assign busy         = busy_q;
    assign fifo.fifo_rd = rd_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        rd_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                txd_d = 1'b1;
                if (en && !fifo.fifo_empty) begin
                    rd_d    = 1'b1;
                    state_d = POP;
                end
            end
            POP: begin
                cnt_d   = '0;
                state_d = LOAD;
            end
            // dout is valid now, one cycle after the FIFO saw rd
            LOAD: begin
                cnt_d   = '0;
                bit_d   = '0;
                shift_d = fifo.fifo_dout;
                txd_d   = 1'b0;
                state_d = START;
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    txd_d   = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        txd_d   = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
        busy_d = (state_d != IDLE);
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: queue-based FIFO model and a per-cycle 8N1 line model.
// Three instances (4, 2 and 300 clocks/bit) share one FIFO model.
module tb_fifo_uart_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] en_r = 3'b000;
    logic [2:0] txd_w, busy_w, rd_w;
    logic       fempty = 1'b1;
    logic [7:0] fdout = 8'h00;
    logic [1:0] sel = 2'd0;
    logic       mon_txd, mon_busy, mon_rd;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int rd_empty = 0;
    int start_cyc = 0;

    logic [7:0] fq[$];
    logic [7:0] exp_q[$];

    fifo_uart_tx_if if0 ();
    fifo_uart_tx_if if1 ();
    fifo_uart_tx_if if2 ();

    assign if0.fifo_empty = fempty;
    assign if1.fifo_empty = fempty;
    assign if2.fifo_empty = fempty;
    assign if0.fifo_dout  = fdout;
    assign if1.fifo_dout  = fdout;
    assign if2.fifo_dout  = fdout;
    assign rd_w = {if2.fifo_rd, if1.fifo_rd, if0.fifo_rd};

    assign mon_txd  = txd_w[sel];
    assign mon_busy = busy_w[sel];
    assign mon_rd   = rd_w[sel];

    fifo_uart_tx #(.CLKS_PER_BIT(4)) u_dut0 (
        .clk (clk), .rst (rst), .en (en_r[0]), .fifo (if0.master),
        .txd (txd_w[0]), .busy (busy_w[0])
    );
    fifo_uart_tx #(.CLKS_PER_BIT(2)) u_dut1 (
        .clk (clk), .rst (rst), .en (en_r[1]), .fifo (if1.master),
        .txd (txd_w[1]), .busy (busy_w[1])
    );
    fifo_uart_tx #(.CLKS_PER_BIT(300)) u_dut2 (
        .clk (clk), .rst (rst), .en (en_r[2]), .fifo (if2.master),
        .txd (txd_w[2]), .busy (busy_w[2])
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clock; the FIFO model pops on an edge that saw rd high.
    task automatic step();
        logic rd_now;
        rd_now = |rd_w;
        @(posedge clk);
        #1;
        cyc++;
        if (rd_now) begin
            if (fq.size() == 0) rd_empty++;
            else fdout = fq.pop_front();
        end
        fempty = (fq.size() == 0);
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        exp_q.push_back(b);
        fempty = 1'b0;
    endtask

    task automatic wait_rd(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (mon_rd) begin
                found = 1'b1;
                break;
            end
            step();
        end
        if (!found && mon_rd) found = 1'b1;
    endtask

    // Observes one frame starting at the cycle where rd is first seen.
    task automatic run_frame(input int n, input logic [7:0] b, input string tag,
                             input int drop_k, input int abort_k);
        int werr, berr, rerr, last, idx;
        logic et, eb, er;
        logic [7:0] got;
        werr = 0;
        berr = 0;
        rerr = 0;
        got  = '0;
        last = 2 + 10 * n;
        for (int k = 0; k <= last; k++) begin
            if (k < 2) et = 1'b1;
            else if (k < 2 + n) et = 1'b0;
            else if (k < 2 + 9 * n) et = b[(k - 2 - n) / n];
            else et = 1'b1;
            eb = (k < last);
            er = (k == 0);
            if (mon_txd !== et) werr++;
            if (mon_busy !== eb) berr++;
            if (mon_rd !== er) rerr++;
            if (k >= 2 + n && k < 2 + 9 * n && ((k - 2 - n) % n) == n / 2) begin
                idx = (k - 2 - n) / n;
                got[idx] = mon_txd;
            end
            if (k == drop_k) en_r[sel] = 1'b0;
            if (k == abort_k) begin
                check({tag, "_pre_txd"}, werr, 0);
                rst = 1'b0;
                step();
                check({tag, "_rst_txd"}, mon_txd, 1);
                check({tag, "_rst_busy"}, mon_busy, 0);
                check({tag, "_rst_rd"}, mon_rd, 0);
                rst = 1'b1;
                return;
            end
            if (k < last) step();
        end
        check({tag, "_txd"}, werr, 0);
        check({tag, "_busy"}, berr, 0);
        check({tag, "_rd"}, rerr, 0);
        check({tag, "_byte"}, got, b);
    endtask

    task automatic do_frame(input int n, input string tag, input int drop_k, input int abort_k);
        bit found;
        logic [7:0] b;
        wait_rd(20, found);
        check({tag, "_start"}, found, 1);
        if (!found) return;
        start_cyc = cyc;
        b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        run_frame(n, b, tag, drop_k, abort_k);
    endtask

    initial begin
        int errs, c0, cnt;
        rst = 1'b0;
        step();
        step();
        check("reset_txd", mon_txd, 1);
        check("reset_busy", mon_busy, 0);
        check("reset_rd", mon_rd, 0);
        rst = 1'b1;

        en_r[0] = 1'b1;
        errs = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (mon_rd || mon_busy || !mon_txd) errs++;
        end
        check("empty_idle", errs, 0);

        push(8'hA5);
        do_frame(4, "a5", -1, -1);
        check("a5_fifo_empty", fempty, 1);

        push(8'h00);
        push(8'hFF);
        do_frame(4, "b2b0", -1, -1);
        c0 = start_cyc;
        do_frame(4, "b2b1", -1, -1);
        check("b2b_spacing", start_cyc - c0, 3 + 10 * 4);

        for (int r = 0; r < 4; r++) begin
            cnt = $urandom_range(1, 3);
            for (int j = 0; j < cnt; j++) push(8'($urandom_range(0, 255)));
            for (int j = 0; j < cnt; j++) do_frame(4, $sformatf("rnd%0d_%0d", r, j), -1, -1);
            for (int j = 0; j < int'($urandom_range(0, 20)); j++) step();
        end

        push(8'h11);
        push(8'h22);
        push(8'h33);
        do_frame(4, "gate0", 2 + 4 * 4 + 1, -1);
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (mon_rd || mon_busy) errs++;
        end
        check("gate_hold", errs, 0);
        en_r[0] = 1'b1;
        do_frame(4, "gate1", -1, -1);
        do_frame(4, "gate2", -1, -1);

        en_r[0] = 1'b1;
        push(8'h5A);
        push(8'hC3);
        do_frame(4, "popdrop", 0, -1);
        errs = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (mon_rd) errs++;
        end
        check("popdrop_hold", errs, 0);
        en_r[0] = 1'b1;
        do_frame(4, "popdrop_next", -1, -1);

        push(8'h96);
        push(8'h69);
        do_frame(4, "abort", -1, 2 + 6 * 4 + 1);
        do_frame(4, "after_abort", -1, -1);

        en_r = 3'b010;
        sel = 2'd1;
        push(8'h3C);
        do_frame(2, "div2", -1, -1);

        en_r = 3'b100;
        sel = 2'd2;
        push(8'h3C);
        do_frame(300, "div300", -1, -1);

        check("rd_when_empty", rd_empty, 0);
        check("fifo_drained", fq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
